// File: rtl/bam_div_pkg.sv
// Shared widths, limits and FSM encoding for the sequential restoring divider.
package bam_div_pkg;

    localparam int DIVIDEND_W = 16;
    localparam int DIVISOR_W  = 8;
    localparam int APPROX_MAX = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/bam_div_step.sv
// One restoring-division step: compare the shifted partial remainder with the divisor.
module bam_div_step
    import bam_div_pkg::*;
(
    input  logic [DIVISOR_W:0]   part_rem,
    input  logic [DIVISOR_W-1:0] divisor,
    output logic [DIVISOR_W-1:0] next_rem,
    output logic                 q_bit
);

    assign q_bit = (part_rem >= {1'b0, divisor});
    // After a successful subtract the value is below the divisor, so it fits in DIVISOR_W bits.
    assign next_rem = q_bit ? DIVISOR_W'(part_rem - {1'b0, divisor}) : part_rem[DIVISOR_W-1:0];

endmodule

// File: rtl/bam_seq_divider_8bits.sv
// Sequential 16/8 unsigned restoring divider, one quotient bit per cycle,
// with optional truncation of the low APPROX_LSBS quotient bits.
module bam_seq_divider_8bits
    import bam_div_pkg::*;
#(
    parameter int APPROX_LSBS = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DIVIDEND_W-1:0] dividend,
    input  logic [DIVISOR_W-1:0]  divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DIVISOR_W-1:0]  quotient,
    output logic [DIVISOR_W-1:0]  remainder,
    output logic                  div_by_zero,
    output logic                  overflow
);

    localparam int         ITERS     = DIVISOR_W - APPROX_LSBS;
    localparam logic [3:0] ITERS_CNT = 4'(ITERS);

    state_t                 state;
    logic [3:0]             iter_cnt;
    logic [DIVISOR_W-1:0]   dvsr;
    logic [DIVISOR_W-1:0]   dvd_lo;
    logic [DIVISOR_W-1:0]   part_rem;
    logic [DIVISOR_W-2:0]   q_acc;
    logic [DIVISOR_W:0]     step_in;
    logic [DIVISOR_W-1:0]   step_rem;
    logic                   step_q;
    logic                   accept;

    // Computed bits land at the bottom of the word; move them up past the skipped LSBs.
    function automatic logic [DIVISOR_W-1:0] align_quotient(input logic [DIVISOR_W-1:0] q_raw);
        return q_raw << APPROX_LSBS;
    endfunction

    function automatic logic [DIVISOR_W-1:0] final_remainder(input logic [DIVISOR_W-1:0] r_raw);
        return (APPROX_LSBS > 0) ? '0 : r_raw;
    endfunction

    assign in_ready  = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = in_valid && (state == IDLE);
    assign step_in   = {part_rem, dvd_lo[DIVISOR_W-1]};

    bam_div_step u_step (
        .part_rem (step_in),
        .divisor  (dvsr),
        .next_rem (step_rem),
        .q_bit    (step_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            iter_cnt    <= '0;
            quotient    <= '0;
            remainder   <= '0;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        iter_cnt <= ITERS_CNT;
                        if (divisor == '0) begin
                            div_by_zero <= 1'b1;
                            overflow    <= 1'b0;
                            quotient    <= '1;
                            remainder   <= dividend[DIVISOR_W-1:0];
                            state       <= DONE;
                        end else if (dividend[DIVIDEND_W-1:DIVISOR_W] >= divisor) begin
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b1;
                            quotient    <= '1;
                            remainder   <= '1;
                            state       <= DONE;
                        end else begin
                            div_by_zero <= 1'b0;
                            overflow    <= 1'b0;
                            state       <= CALC;
                        end
                    end
                end
                CALC: begin
                    iter_cnt <= iter_cnt - 4'd1;
                    if (iter_cnt == 4'd1) begin
                        quotient  <= align_quotient({q_acc, step_q});
                        remainder <= final_remainder(step_rem);
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath: operand capture on accept, one restoring step per CALC cycle.
    always_ff @(posedge clk) begin
        if (accept) begin
            dvsr     <= divisor;
            dvd_lo   <= dividend[DIVISOR_W-1:0];
            part_rem <= dividend[DIVIDEND_W-1:DIVISOR_W];
            q_acc    <= '0;
        end else if (state == CALC) begin
            part_rem <= step_rem;
            dvd_lo   <= {dvd_lo[DIVISOR_W-2:0], 1'b0};
            q_acc    <= {q_acc[DIVISOR_W-3:0], step_q};
        end
    end

endmodule

// File: doc/bam_seq_divider_8bits.md
BAM_SEQ_DIVIDER_8BITS -- requirements
Module: bam_seq_divider_8bits

Interface
REQ-001 SHALL have parameter APPROX_LSBS, default 0, giving the number of quotient LSBs not computed (legal 0..4); 0 means an exact divider.
REQ-002 SHALL have port clk, input, 1 bit: single clock; every register updates on the rising edge.
REQ-003 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-004 SHALL have port in_valid, input, 1 bit: dividend and divisor are presented.
REQ-005 SHALL have port in_ready, output, 1 bit: block can accept an operation.
REQ-006 SHALL have port dividend, input, 16 bits: unsigned product-width operand P.
REQ-007 SHALL have port divisor, input, 8 bits: unsigned operand B.
REQ-008 SHALL have port out_valid, output, 1 bit: result is available.
REQ-009 SHALL have port out_ready, input, 1 bit: consumer accepts the result.
REQ-010 SHALL have port quotient, output, 8 bits: unsigned quotient.
REQ-011 SHALL have port remainder, output, 8 bits: unsigned remainder.
REQ-012 SHALL have port div_by_zero, output, 1 bit: divisor was 0.
REQ-013 SHALL have port overflow, output, 1 bit: quotient does not fit in 8 bits (dividend[15:8] >= divisor, divisor != 0).

Function
REQ-014 SHALL implement FSM states IDLE, CALC, DONE; in_ready = 1 only in IDLE, out_valid = 1 only in DONE.
REQ-015 SHALL accept an operation when in_valid && in_ready, capturing dividend and divisor; inputs are ignored in all other cycles.
REQ-016 SHALL, on accept with divisor == 0, go to DONE next cycle with div_by_zero=1, overflow=0, quotient=8'hFF, remainder=dividend[7:0].
REQ-017 SHALL, on accept with overflow condition, go to DONE next cycle with overflow=1, div_by_zero=0, quotient=8'hFF, remainder=8'hFF.
REQ-018 SHALL otherwise enter CALC with a 9-bit partial remainder initialised to dividend[15:8] and an iteration counter of 8-APPROX_LSBS.
REQ-019 SHALL, per CALC cycle, perform one restoring step: shift the partial remainder left, bringing in the next dividend bit MSB-first; if the result >= divisor, subtract divisor and set the quotient bit to 1, else 0; decrement the counter.
REQ-020 SHALL go CALC->DONE after the last iteration; exact latency from accept to out_valid = 1 + (8-APPROX_LSBS) cycles (9 when APPROX_LSBS=0).
REQ-021 SHALL, when APPROX_LSBS>0, force the low APPROX_LSBS quotient bits to 0 and the remainder to 8'h00.
REQ-022 SHALL hold quotient, remainder and flags stable while out_valid=1 and out_ready=0.
REQ-023 SHALL go DONE->IDLE on out_valid && out_ready; in_ready rises the following cycle, with no same-cycle accept.
REQ-024 SHALL ensure the results satisfy dividend = quotient*divisor + remainder with remainder < divisor for every non-flagged exact operation.

Reset
REQ-025 SHALL, while rst=1 at a clock edge, enter IDLE and drive in_ready=1, out_valid=0, quotient=0, remainder=0, div_by_zero=0, overflow=0.
REQ-026 SHALL abandon any in-flight operation (CALC or DONE) on reset with no result emitted afterwards.

Structure
REQ-027 SHALL place the operand width constants (16/8), the FSM state enum and the APPROX_LSBS legal maximum in shared package bam_div_pkg.
REQ-028 SHALL implement the single restoring step as combinational sub-module bam_div_step (9-bit partial remainder, 8-bit divisor -> new remainder, quotient bit), instantiated once.

Verification
REQ-029 SHALL cover exact division: dividend 16'h3039, divisor 8'h7B -> quotient 8'h64, remainder 8'h2D, flags 0, out_valid 9 cycles after accept.
REQ-030 SHALL cover divide by zero: dividend 16'h1234, divisor 8'h00 -> div_by_zero=1, quotient 8'hFF, remainder 8'h34, out_valid 1 cycle after accept.
REQ-031 SHALL cover overflow: dividend 16'h8000, divisor 8'h80 -> overflow=1, quotient 8'hFF, remainder 8'hFF.
REQ-032 SHALL cover approximation with APPROX_LSBS=2: dividend 16'h00FF, divisor 8'h01 -> quotient 8'hFC, remainder 8'h00, latency 7 cycles.
REQ-033 SHALL cover backpressure: out_ready held 0 for 5 cycles in DONE -> outputs stable, in_ready=0; then 1 cycle of out_ready=1 -> in_ready=1 next cycle.
REQ-034 SHALL cover reset mid-operation: rst asserted in the 4th CALC cycle -> IDLE outputs as in REQ-025, no out_valid pulse; a new operation afterwards yields correct results.
